// File: rtl/div_req_pkg.sv
// Shared types and helpers for the divider request controller.
package div_req_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'd0,
    OpDivu = 2'd1,
    OpRem  = 2'd2,
    OpRemu = 2'd3
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } div_req_state_e;

  function automatic logic is_signed_op(div_op_e op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_rem_op(div_op_e op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/div_req_ctrl_if.sv
// Request, divider and response signals of div_req_ctrl; slave is the controller side.
interface div_req_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
) ();

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic [1:0]            req_op_i;
  logic [DATA_WIDTH-1:0] req_a_i;
  logic [DATA_WIDTH-1:0] req_b_i;
  logic [TAG_WIDTH-1:0]  req_tag_i;
  logic                  div_enable_o;
  logic [DATA_WIDTH-1:0] dividend_o;
  logic [DATA_WIDTH-1:0] divisor_o;
  logic                  division_finished_i;
  logic [DATA_WIDTH-1:0] result_div_i;
  logic [DATA_WIDTH-1:0] result_rem_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic [TAG_WIDTH-1:0]  rsp_tag_o;
  logic                  busy_o;

  modport slave (
    input  req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i,
    input  division_finished_i, result_div_i, result_rem_i, rsp_ready_i,
    output req_ready_o, div_enable_o, dividend_o, divisor_o,
    output rsp_valid_o, rsp_data_o, rsp_tag_o, busy_o
  );

  modport master (
    output req_valid_i, req_op_i, req_a_i, req_b_i, req_tag_i,
    output division_finished_i, result_div_i, result_rem_i, rsp_ready_i,
    input  req_ready_o, div_enable_o, dividend_o, divisor_o,
    input  rsp_valid_o, rsp_data_o, rsp_tag_o, busy_o
  );

endinterface

// File: rtl/div_sign_fix.sv
// Combinational sign fix-up of unsigned divider results for RISC-V DIV/DIVU/REM/REMU.
module div_sign_fix
  import div_req_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  div_op_e               op_i,
  input  logic                  sign_a_i,
  input  logic                  sign_b_i,
  input  logic [DATA_WIDTH-1:0] quo_i,
  input  logic [DATA_WIDTH-1:0] rem_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  logic                  is_rem;
  logic                  negate;
  logic [DATA_WIDTH-1:0] mag;

  // Quotient sign is sign(a)^sign(b); remainder follows the dividend.
  assign is_rem   = is_rem_op(op_i);
  assign negate   = is_signed_op(op_i) & (is_rem ? sign_a_i : (sign_a_i ^ sign_b_i));
  assign mag      = is_rem ? rem_i : quo_i;
  assign result_o = negate ? -mag : mag;

endmodule

// File: rtl/div_req_ctrl.sv
// Request-side controller for the multicycle divider with sign and special-case fix-up.
// Define DIV_REQ_REUSE_EN to answer repeated {a, b, signedness} requests from the last result.
module div_req_ctrl
  import div_req_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_WIDTH  = 5
) (
  input logic          clk,
  input logic          rst,
  div_req_ctrl_if.slave bus
);

  localparam logic [DATA_WIDTH-1:0] MostNeg = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  div_req_state_e        state_q, state_d;
  div_op_e               op_q, req_op, fix_op;
  logic                  sign_a_q, sign_b_q;
  logic [DATA_WIDTH-1:0] dividend_q, divisor_q;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;

  logic                  accept, req_signed, req_rem, req_sign_a, req_sign_b;
  logic                  div_by_zero, overflow, special, reuse_hit;
  logic [DATA_WIDTH-1:0] special_data, mag_a, mag_b;
  logic                  fix_sign_a, fix_sign_b;
  logic [DATA_WIDTH-1:0] fix_quo, fix_rem, fix_result;

  assign req_op     = div_op_e'(bus.req_op_i);
  assign req_signed = is_signed_op(req_op);
  assign req_rem    = is_rem_op(req_op);
  assign req_sign_a = req_signed & bus.req_a_i[DATA_WIDTH-1];
  assign req_sign_b = req_signed & bus.req_b_i[DATA_WIDTH-1];
  // Negating the most-negative value yields 2^(W-1), the correct unsigned magnitude.
  assign mag_a      = req_sign_a ? -bus.req_a_i : bus.req_a_i;
  assign mag_b      = req_sign_b ? -bus.req_b_i : bus.req_b_i;

  assign accept      = bus.req_valid_i & bus.req_ready_o;
  assign div_by_zero = (bus.req_b_i == '0);
  assign overflow    = req_signed && (bus.req_a_i == MostNeg) && (bus.req_b_i == '1);
  assign special     = div_by_zero | overflow;

  always_comb begin
    special_data = '0;
    if (div_by_zero) begin
      special_data = req_rem ? bus.req_a_i : '1;
    end else begin
      special_data = req_rem ? '0 : bus.req_a_i;
    end
  end

`ifdef DIV_REQ_REUSE_EN
  logic                  reuse_valid_q, reuse_signed_q;
  logic [DATA_WIDTH-1:0] reuse_a_q, reuse_b_q, reuse_quo_q, reuse_rem_q;

  assign reuse_hit = reuse_valid_q && (reuse_a_q == bus.req_a_i) &&
                     (reuse_b_q == bus.req_b_i) && (reuse_signed_q == req_signed);

  // In IDLE the fix-up path serves reuse hits; elsewhere it serves the divider.
  assign fix_op     = (state_q == StIdle) ? req_op      : op_q;
  assign fix_sign_a = (state_q == StIdle) ? req_sign_a  : sign_a_q;
  assign fix_sign_b = (state_q == StIdle) ? req_sign_b  : sign_b_q;
  assign fix_quo    = (state_q == StIdle) ? reuse_quo_q : bus.result_div_i;
  assign fix_rem    = (state_q == StIdle) ? reuse_rem_q : bus.result_rem_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      reuse_valid_q  <= 1'b0;
      reuse_signed_q <= 1'b0;
      reuse_a_q      <= '0;
      reuse_b_q      <= '0;
      reuse_quo_q    <= '0;
      reuse_rem_q    <= '0;
    end else if (accept && !special && !reuse_hit) begin
      reuse_valid_q  <= 1'b0;
      reuse_signed_q <= req_signed;
      reuse_a_q      <= bus.req_a_i;
      reuse_b_q      <= bus.req_b_i;
    end else if (state_q == StWait && bus.division_finished_i) begin
      reuse_valid_q <= 1'b1;
      reuse_quo_q   <= bus.result_div_i;
      reuse_rem_q   <= bus.result_rem_i;
    end
  end
`else
  assign reuse_hit  = 1'b0;
  assign fix_op     = op_q;
  assign fix_sign_a = sign_a_q;
  assign fix_sign_b = sign_b_q;
  assign fix_quo    = bus.result_div_i;
  assign fix_rem    = bus.result_rem_i;
`endif

  div_sign_fix #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_sign_fix (
    .op_i    (fix_op),
    .sign_a_i(fix_sign_a),
    .sign_b_i(fix_sign_b),
    .quo_i   (fix_quo),
    .rem_i   (fix_rem),
    .result_o(fix_result)
  );

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (special) begin
            state_d    = StResp;
            rsp_data_d = special_data;
          end else if (reuse_hit) begin
            state_d    = StResp;
            rsp_data_d = fix_result;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (bus.division_finished_i) begin
          state_d    = StResp;
          rsp_data_d = fix_result;
        end
      end
      StResp: begin
        if (bus.rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= OpDiv;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      if (accept) begin
        op_q       <= req_op;
        sign_a_q   <= req_sign_a;
        sign_b_q   <= req_sign_b;
        dividend_q <= mag_a;
        divisor_q  <= mag_b;
        rsp_tag_q  <= bus.req_tag_i;
      end
    end
  end

  assign bus.req_ready_o  = (state_q == StIdle) & ~rst;
  assign bus.div_enable_o = (state_q == StIssue);
  assign bus.rsp_valid_o  = (state_q == StResp);
  assign bus.busy_o       = (state_q != StIdle);
  assign bus.dividend_o   = dividend_q;
  assign bus.divisor_o    = divisor_q;
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.rsp_tag_o    = rsp_tag_q;

endmodule

// File: tb/tb_div_req_ctrl.sv
// Directed bench for div_req_ctrl with a fixed-latency divider model.
module tb_div_req_ctrl;

`ifdef DIV_REQ_REUSE_EN
  localparam bit ReuseEn = 1'b1;
`else
  localparam bit ReuseEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic        model_fin = 1'b0;
  logic        stray_fin = 1'b0;
  int          cnt = 0;
  logic [31:0] m_dvd = '0;
  logic [31:0] m_dvs = '0;

  div_req_ctrl_if #(.DATA_WIDTH(32), .TAG_WIDTH(5)) bus ();

  div_req_ctrl #(.DATA_WIDTH(32), .TAG_WIDTH(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  assign bus.division_finished_i = model_fin | stray_fin;

  // Divider model: finished three negedges after it sees div_enable_o.
  always @(negedge clk) begin
    model_fin <= 1'b0;
    if (!bus.busy_o) begin
      cnt <= 0;
    end else if (bus.div_enable_o) begin
      cnt   <= 3;
      m_dvd <= bus.dividend_o;
      m_dvs <= bus.divisor_o;
    end else if (cnt == 1) begin
      cnt              <= 0;
      model_fin        <= 1'b1;
      bus.result_div_i <= (m_dvs == 0) ? 32'hFFFF_FFFF : m_dvd / m_dvs;
      bus.result_rem_i <= (m_dvs == 0) ? m_dvd : m_dvd % m_dvs;
    end else if (cnt > 1) begin
      cnt <= cnt - 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Starts at a negedge in IDLE; returns at a negedge after the response handshake.
  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int hold,
                        output logic [31:0] data, output logic [4:0] rtag, output int lat,
                        output int ens, output int en_cyc, output logic [31:0] dvd,
                        output logic [31:0] dvs, output bit stable);
    data = '0; rtag = '0; lat = 0; ens = 0; en_cyc = 0; dvd = '0; dvs = '0; stable = 1'b1;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_a_i     = a;
    bus.req_b_i     = b;
    bus.req_tag_i   = tag;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      if (bus.div_enable_o) begin
        ens++;
        if (en_cyc == 0) en_cyc = k;
        dvd = bus.dividend_o;
        dvs = bus.divisor_o;
      end
      if (bus.rsp_valid_o) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    check_eq("rsp_seen", 64'(lat != 0), 64'd1);
    if (lat != 0) begin
      data = bus.rsp_data_o;
      rtag = bus.rsp_tag_o;
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!bus.rsp_valid_o || bus.rsp_data_o !== data || bus.rsp_tag_o !== rtag) stable = 1'b0;
      end
      bus.rsp_ready_i = 1'b1;
      @(negedge clk);
      bus.rsp_ready_i = 1'b0;
    end
  endtask

  task automatic run_vec(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp_data,
                         input bit fast, input logic [31:0] exp_dvd, input logic [31:0] exp_dvs);
    logic [31:0] data, dvd, dvs;
    logic [4:0]  rtag;
    int          lat, ens, en_cyc;
    bit          stable;
    do_req(op, a, b, tag, 0, data, rtag, lat, ens, en_cyc, dvd, dvs, stable);
    check_eq({name, ".data"}, 64'(data), 64'(exp_data));
    check_eq({name, ".tag"}, 64'(rtag), 64'(tag));
    check_eq({name, ".lat"}, 64'(lat), fast ? 64'd1 : 64'd5);
    check_eq({name, ".ens"}, 64'(ens), fast ? 64'd0 : 64'd1);
    if (!fast) begin
      check_eq({name, ".en_cyc"}, 64'(en_cyc), 64'd1);
      check_eq({name, ".dvd"}, 64'(dvd), 64'(exp_dvd));
      check_eq({name, ".dvs"}, 64'(dvs), 64'(exp_dvs));
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check_eq({name, ".en"}, 64'(bus.div_enable_o), 64'd0);
    check_eq({name, ".valid"}, 64'(bus.rsp_valid_o), 64'd0);
    check_eq({name, ".busy"}, 64'(bus.busy_o), 64'd0);
    check_eq({name, ".dvd"}, 64'(bus.dividend_o), 64'd0);
    check_eq({name, ".dvs"}, 64'(bus.divisor_o), 64'd0);
    check_eq({name, ".data"}, 64'(bus.rsp_data_o), 64'd0);
    check_eq({name, ".tag"}, 64'(bus.rsp_tag_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] data, dvd, dvs;
    logic [4:0]  rtag;
    int          lat, ens, en_cyc;
    bit          stable;

    bus.req_valid_i = 1'b0;
    bus.req_op_i    = '0;
    bus.req_a_i     = '0;
    bus.req_b_i     = '0;
    bus.req_tag_i   = '0;
    bus.rsp_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    check_eq("rst.ready", 64'(bus.req_ready_o), 64'd0);
    check_reset_outputs("rst");
    rst = 1'b0;
    #1;
    check_eq("rst.ready_after", 64'(bus.req_ready_o), 64'd1);
    @(negedge clk);

    run_vec("divu_100_7", 2'd1, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0, 32'd100, 32'd7);
    run_vec("div_m100_7", 2'd0, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFF2, 1'b0, 32'd100, 32'd7);
    run_vec("rem_m100_7", 2'd2, 32'hFFFF_FF9C, 32'd7, 5'd7, 32'hFFFF_FFFE, ReuseEn, 32'd100,
            32'd7);
    run_vec("divu_big_7", 2'd1, 32'hFFFF_FF9C, 32'd7, 5'd20, 32'h2492_4916, 1'b0, 32'hFFFF_FF9C,
            32'd7);
    run_vec("divu_5_0", 2'd1, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'd0);
    run_vec("remu_5_0", 2'd3, 32'd5, 32'd0, 5'd9, 32'd5, 1'b1, 32'd0, 32'd0);
    run_vec("div_ovf", 2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1'b1, 32'd0,
            32'd0);
    run_vec("rem_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 1'b1, 32'd0, 32'd0);
    run_vec("div_7_m2", 2'd0, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'hFFFF_FFFD, 1'b0, 32'd7, 32'd2);
    run_vec("rem_7_m2", 2'd2, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'd1, ReuseEn, 32'd7, 32'd2);
    run_vec("div_m7_m2", 2'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd14, 32'd3, 1'b0, 32'd7, 32'd2);
    run_vec("rem_m7_m2", 2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd15, 32'hFFFF_FFFF, ReuseEn,
            32'd7, 32'd2);
    run_vec("div_min_2", 2'd0, 32'h8000_0000, 32'd2, 5'd16, 32'hC000_0000, 1'b0, 32'h8000_0000,
            32'd2);
    run_vec("divu_max_16", 2'd1, 32'hFFFF_FFFF, 32'd16, 5'd17, 32'h0FFF_FFFF, 1'b0,
            32'hFFFF_FFFF, 32'd16);
    run_vec("remu_max_16", 2'd3, 32'hFFFF_FFFF, 32'd16, 5'd18, 32'h0000_000F, ReuseEn,
            32'hFFFF_FFFF, 32'd16);

    // Back-pressure: response must hold for 10 cycles, then drop after the handshake.
    do_req(2'd1, 32'd100, 32'd7, 5'd21, 10, data, rtag, lat, ens, en_cyc, dvd, dvs, stable);
    check_eq("hold.data", 64'(data), 64'd14);
    check_eq("hold.tag", 64'(rtag), 64'd21);
    check_eq("hold.stable", 64'(stable), 64'd1);
    check_eq("hold.drop", 64'(bus.rsp_valid_o), 64'd0);

    // A stray finished pulse in IDLE must not create a response.
    stray_fin = 1'b1;
    @(negedge clk);
    stray_fin = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("stray.valid", 64'(bus.rsp_valid_o), 64'd0);
    check_eq("stray.busy", 64'(bus.busy_o), 64'd0);
    check_eq("stray.ready", 64'(bus.req_ready_o), 64'd1);

    // Reset during WAIT aborts the operation.
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 2'd1;
    bus.req_a_i     = 32'd1000;
    bus.req_b_i     = 32'd10;
    bus.req_tag_i   = 5'd22;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check_eq("abort.busy_pre", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort.ready", 64'(bus.req_ready_o), 64'd0);
    check_reset_outputs("abort");
    rst = 1'b0;
    #1;
    check_eq("abort.ready_after", 64'(bus.req_ready_o), 64'd1);
    repeat (6) @(negedge clk);
    check_eq("abort.no_rsp", 64'(bus.rsp_valid_o), 64'd0);

    run_vec("divu_9_3", 2'd1, 32'd9, 32'd3, 5'd1, 32'd3, 1'b0, 32'd9, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
